// File: rtl/mcs6530_bus_master.sv
// Host-to-6502 bus initiator for the 6530 responder: turns single-byte read/write
// commands into PHI2-phased bus cycles and reports completion on a response strobe.
module mcs6530_bus_master #(
  parameter int PHI_DIV    = 4,
  parameter int RES_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [9:0] cmd_addr,
  input  logic       cmd_rs0,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       phi2_o,
  output logic       res_n_o,
  output logic [9:0] a_o,
  output logic       rs0_o,
  output logic       cs1_o,
  output logic       we_n_o,
  output logic [7:0] db_o,
  output logic       db_oe,
  input  logic [7:0] db_i
);

  localparam int PW = $clog2(2 * PHI_DIV);
  localparam int RW = (RES_CYCLES > 1) ? $clog2(RES_CYCLES) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(2 * PHI_DIV - 1);
  localparam logic [PW-1:0] PH_PRE  = PW'(PHI_DIV - 1);
  localparam logic [RW-1:0] RES_LAST = RW'(RES_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET_HOLD,
    S_IDLE,
    S_PEND,
    S_ACTIVE
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_phase;
  logic [PW-1:0] w_phase_next;
  logic          w_last;
  logic [RW-1:0] r_res_cnt;
  logic          r_phi2;
  logic          r_res_n;

  logic          w_ready;
  logic          w_accept;
  logic          w_load_latch;
  logic          w_load_direct;
  logic          w_go_idle;

  logic          r_cmd_we;
  logic [9:0]    r_cmd_addr;
  logic          r_cmd_rs0;
  logic [7:0]    r_cmd_wdata;

  logic [9:0]    w_src_addr;
  logic          w_src_rs0;
  logic          w_src_we;

  logic [9:0]    r_a;
  logic          r_rs0;
  logic          r_cs1;
  logic          r_we_n;
  logic [7:0]    r_db;
  logic          r_db_oe;
  logic          r_rsp_valid;
  logic [7:0]    r_rsp_rdata;

  assign w_last       = (r_phase == PH_LAST);
  assign w_phase_next = w_last ? '0 : r_phase + 1'b1;

  // phi2 is registered from the next phase so it lines up with the phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
      r_phi2  <= 1'b0;
    end else begin
      r_phase <= w_phase_next;
      r_phi2  <= (w_phase_next > PH_PRE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RESET_HOLD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_ready       = 1'b0;
    w_load_latch  = 1'b0;
    w_load_direct = 1'b0;
    w_go_idle     = 1'b0;
    case (r_state)
      S_RESET_HOLD: begin
        if (w_last && (r_res_cnt == RES_LAST)) begin
          w_state_next = S_IDLE;
        end
      end
      S_IDLE: begin
        w_ready = 1'b1;
        if (cmd_valid) begin
          w_state_next = S_PEND;
        end
      end
      S_PEND: begin
        if (w_last) begin
          w_load_latch = 1'b1;
          w_state_next = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_last) begin
          w_ready = 1'b1;
          // A command taken on the last phase starts its bus cycle immediately.
          if (cmd_valid) begin
            w_load_direct = 1'b1;
          end else begin
            w_go_idle    = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_RESET_HOLD;
      end
    endcase
  end

  assign w_accept = cmd_valid && w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_cnt <= '0;
      r_res_n   <= 1'b0;
    end else if (r_state == S_RESET_HOLD) begin
      if (w_last) begin
        r_res_cnt <= r_res_cnt + 1'b1;
      end
      if (w_state_next == S_IDLE) begin
        r_res_n <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_rs0   <= 1'b0;
      r_cmd_wdata <= '0;
    end else if (w_accept) begin
      r_cmd_we    <= cmd_we;
      r_cmd_addr  <= cmd_addr;
      r_cmd_rs0   <= cmd_rs0;
      r_cmd_wdata <= cmd_wdata;
    end
  end

  assign w_src_addr = w_load_direct ? cmd_addr : r_cmd_addr;
  assign w_src_rs0  = w_load_direct ? cmd_rs0  : r_cmd_rs0;
  assign w_src_we   = w_load_direct ? cmd_we   : r_cmd_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_rs0  <= 1'b0;
      r_cs1  <= 1'b0;
      r_we_n <= 1'b1;
    end else if (w_load_latch || w_load_direct) begin
      r_a    <= w_src_addr;
      r_rs0  <= w_src_rs0;
      r_cs1  <= 1'b1;
      r_we_n <= ~w_src_we;
    end else if (w_go_idle) begin
      r_cs1  <= 1'b0;
      r_we_n <= 1'b1;
    end
  end

  // Write data is driven from the PHI2 rise and held one clk past the PHI2 fall;
  // db_o only changes when the driver turns on, so the hold carries the old byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db    <= '0;
      r_db_oe <= 1'b0;
    end else if ((r_phase == PH_PRE) && (r_state == S_ACTIVE) && r_cmd_we) begin
      r_db    <= r_cmd_wdata;
      r_db_oe <= 1'b1;
    end else if (r_phase == '0) begin
      r_db_oe <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= (r_state == S_ACTIVE) && w_last;
      if ((r_state == S_ACTIVE) && w_last) begin
        r_rsp_rdata <= r_cmd_we ? 8'h00 : db_i;
      end
    end
  end

  assign cmd_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign phi2_o    = r_phi2;
  assign res_n_o   = r_res_n;
  assign a_o       = r_a;
  assign rs0_o     = r_rs0;
  assign cs1_o     = r_cs1;
  assign we_n_o    = r_we_n;
  assign db_o      = r_db;
  assign db_oe     = r_db_oe;

endmodule

// File: tb/tb_mcs6530_bus_master.sv
// Bench for mcs6530_bus_master: host commands feed a response scoreboard, and each
// scenario checks the bus pin sequence against its own expected phase pattern.
module tb_mcs6530_bus_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_we = 1'b0;
  logic [9:0] cmd_addr = '0;
  logic       cmd_rs0 = 1'b0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       phi2_o;
  logic       res_n_o;
  logic [9:0] a_o;
  logic       rs0_o;
  logic       cs1_o;
  logic       we_n_o;
  logic [7:0] db_o;
  logic       db_oe;
  logic [7:0] db_i;

  typedef struct packed {
    logic       we;
    logic [9:0] addr;
    logic       rs0;
    logic [7:0] wdata;
  } cmd_t;

  cmd_t       stim_q[$];
  logic [7:0] exp_q[$];
  bit         acc_flag = 1'b0;
  logic [7:0] rd_xor = 8'h00;
  int         tb_phase = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  mcs6530_bus_master #(.PHI_DIV(4), .RES_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_rs0(cmd_rs0), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .phi2_o(phi2_o), .res_n_o(res_n_o), .a_o(a_o), .rs0_o(rs0_o),
    .cs1_o(cs1_o), .we_n_o(we_n_o), .db_o(db_o), .db_oe(db_oe), .db_i(db_i)
  );

  always #5 clk = ~clk;

  // Reference phase counter, restarted by rst exactly like the bus clock divider.
  always @(posedge clk) tb_phase <= (rst || tb_phase == 7) ? 0 : tb_phase + 1;

  // Responder model: drives a byte derived from the address while PHI2 is high.
  assign db_i = phi2_o ? (a_o[7:0] ^ rd_xor) : 8'h00;

  always @(negedge clk) begin : rsp_monitor
    logic [7:0] exp;
    if (rsp_valid === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: rsp_valid with rdata=%02h, required no response", rsp_rdata);
      end else begin
        exp = exp_q.pop_front();
        if (rsp_rdata !== exp) begin
          n_fail++;
          $display("FAIL rsp_rdata: got %02h, required %02h", rsp_rdata, exp);
        end else begin
          $display("RSP rdata=%02h (expected %02h)", rsp_rdata, exp);
        end
      end
    end
  end

  // Host driver: presents queued commands and records the expected response on accept.
  task automatic host_step();
    cmd_t c;
    if (acc_flag) begin
      acc_flag  = 1'b0;
      cmd_valid = 1'b0;
    end
    if (!cmd_valid && stim_q.size() > 0) begin
      c         = stim_q.pop_front();
      cmd_valid = 1'b1;
      cmd_we    = c.we;
      cmd_addr  = c.addr;
      cmd_rs0   = c.rs0;
      cmd_wdata = c.wdata;
    end
    if (cmd_valid && cmd_ready === 1'b1) begin
      exp_q.push_back(cmd_we ? 8'h00 : (cmd_addr[7:0] ^ rd_xor));
      acc_flag = 1'b1;
      $display("CMD we=%0b addr=%03h rs0=%0b wdata=%02h", cmd_we, cmd_addr, cmd_rs0, cmd_wdata);
    end
  endtask

  task automatic test_reset();
    int low_cnt = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({phi2_o, res_n_o, cmd_ready, rsp_valid, rsp_rdata, a_o, rs0_o, cs1_o, we_n_o, db_o, db_oe}
        !== {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got phi2=%b res_n=%b rdy=%b rv=%b rd=%h a=%h rs0=%b cs1=%b wen=%b db=%h oe=%b, required 0 0 0 0 00 000 0 0 1 00 0",
               phi2_o, res_n_o, cmd_ready, rsp_valid, rsp_rdata, a_o, rs0_o, cs1_o, we_n_o, db_o, db_oe);
    end
    for (int i = 0; i < 80; i++) begin
      if (res_n_o === 1'b0) low_cnt++;
      n_chk++;
      if (phi2_o !== (tb_phase >= 4)) begin
        n_fail++;
        $display("FAIL reset_phi2: sample %0d got %b, required %b", i, phi2_o, tb_phase >= 4);
      end
      n_chk++;
      if (cmd_ready !== res_n_o) begin
        n_fail++;
        $display("FAIL reset_ready: sample %0d got cmd_ready=%b, required %b", i, cmd_ready, res_n_o);
      end
      @(negedge clk);
    end
    n_chk++;
    if (low_cnt != 64) begin
      n_fail++;
      $display("FAIL reset_len: res_n_o low for %0d clks, required 64", low_cnt);
    end
    $display("RESET res_n_o low for %0d clks", low_cnt);
  endtask

  task automatic test_write();
    int k = -1;
    logic [14:0] got, req;
    stim_q.push_back('{1'b1, 10'h3C5, 1'b1, 8'hA5});
    for (int i = 0; i < 80 && k < 10; i++) begin
      @(negedge clk);
      if (k < 0 && cs1_o === 1'b1) begin
        k = 0;
        n_chk++;
        if (tb_phase != 0) begin
          n_fail++;
          $display("FAIL write_start_phase: cs1 rose at phase %0d, required 0", tb_phase);
        end
      end
      if (k >= 0) begin
        got = {cs1_o, we_n_o, db_oe, rsp_valid, rs0_o, a_o};
        req = {k < 8, k >= 8, k >= 4 && k <= 8, k == 8, 1'b1, 10'h3C5};
        n_chk++;
        if (got !== req) begin
          n_fail++;
          $display("FAIL write_bus k=%0d: got cs1/wen/oe/rv/rs0/a=%h, required %h", k, got, req);
        end
        if (db_oe === 1'b1) begin
          n_chk++;
          if (db_o !== 8'hA5) begin
            n_fail++;
            $display("FAIL write_data k=%0d: got %02h, required a5", k, db_o);
          end
        end
        k++;
      end
      host_step();
    end
    n_chk++;
    if (k < 10) begin
      n_fail++;
      $display("FAIL write_timeout: window reached %0d, required 10", k);
    end
  endtask

  task automatic test_read();
    int k = -1;
    logic [14:0] got, req;
    rd_xor = 8'h5A;
    stim_q.push_back('{1'b0, 10'h200, 1'b0, 8'h00});
    for (int i = 0; i < 80 && k < 10; i++) begin
      @(negedge clk);
      if (k < 0 && cs1_o === 1'b1) k = 0;
      if (k >= 0) begin
        got = {cs1_o, we_n_o, db_oe, rsp_valid, rs0_o, a_o};
        req = {k < 8, 1'b1, 1'b0, k == 8, 1'b0, 10'h200};
        n_chk++;
        if (got !== req) begin
          n_fail++;
          $display("FAIL read_bus k=%0d: got cs1/wen/oe/rv/rs0/a=%h, required %h", k, got, req);
        end
        if (k == 8) begin
          n_chk++;
          if (rsp_rdata !== 8'h5A) begin
            n_fail++;
            $display("FAIL read_data: got %02h, required 5a", rsp_rdata);
          end
        end
        k++;
      end
      host_step();
    end
    n_chk++;
    if (k < 10) begin
      n_fail++;
      $display("FAIL read_timeout: window reached %0d, required 10", k);
    end
  endtask

  task automatic test_back_to_back();
    int k = -1;
    logic [15:0] got, req;
    rd_xor = 8'h3C;
    stim_q.push_back('{1'b0, 10'h011, 1'b1, 8'h00});
    stim_q.push_back('{1'b0, 10'h0F2, 1'b0, 8'h00});
    for (int i = 0; i < 120 && k < 18; i++) begin
      @(negedge clk);
      if (k < 0 && cs1_o === 1'b1) k = 0;
      if (k >= 0) begin
        got = {cmd_ready, cs1_o, we_n_o, db_oe, rsp_valid, rs0_o, a_o};
        req = {(k % 8 == 7) || k >= 16, k < 16, 1'b1, 1'b0, k == 8 || k == 16,
               k < 8, (k < 8) ? 10'h011 : 10'h0F2};
        n_chk++;
        if (got !== req) begin
          n_fail++;
          $display("FAIL b2b_bus k=%0d: got rdy/cs1/wen/oe/rv/rs0/a=%h, required %h", k, got, req);
        end
        k++;
      end
      host_step();
    end
    n_chk++;
    if (k < 18) begin
      n_fail++;
      $display("FAIL b2b_timeout: window reached %0d, required 18", k);
    end
  endtask

  task automatic test_pend_ignore();
    int k = -1;
    logic [14:0] got, req;
    stim_q.push_back('{1'b1, 10'h155, 1'b0, 8'h3E});
    stim_q.push_back('{1'b1, 10'h2AA, 1'b1, 8'hC1});
    for (int i = 0; i < 120 && k < 18; i++) begin
      @(negedge clk);
      if (k < 0 && cs1_o === 1'b1) k = 0;
      if (k >= 0) begin
        got = {cs1_o, we_n_o, db_oe, rsp_valid, rs0_o, a_o};
        req = {k < 16, k >= 16, (k >= 4 && k <= 8) || (k >= 12 && k <= 16),
               k == 8 || k == 16, k >= 8, (k < 8) ? 10'h155 : 10'h2AA};
        n_chk++;
        if (got !== req) begin
          n_fail++;
          $display("FAIL pend_bus k=%0d: got cs1/wen/oe/rv/rs0/a=%h, required %h", k, got, req);
        end
        if (db_oe === 1'b1) begin
          n_chk++;
          if (db_o !== ((k <= 8) ? 8'h3E : 8'hC1)) begin
            n_fail++;
            $display("FAIL pend_data k=%0d: got %02h, required %02h", k, db_o, (k <= 8) ? 8'h3E : 8'hC1);
          end
        end
        k++;
      end
      host_step();
    end
    n_chk++;
    if (k < 18) begin
      n_fail++;
      $display("FAIL pend_timeout: window reached %0d, required 18", k);
    end
  endtask

  task automatic test_rst_midcycle();
    int k = -1;
    int low_cnt = 0;
    int rv_cnt = 0;
    stim_q.push_back('{1'b1, 10'h0AB, 1'b1, 8'h77});
    for (int i = 0; i < 80 && k < 5; i++) begin
      @(negedge clk);
      if (k < 0 && cs1_o === 1'b1) k = 0;
      else if (k >= 0) k++;
      host_step();
    end
    n_chk++;
    if (k != 5 || db_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_setup: got k=%0d db_oe=%b, required k=5 db_oe=1", k, db_oe);
    end
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    acc_flag  = 1'b0;
    n_chk++;
    if ({db_oe, cs1_o, we_n_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL abort_bus: got oe/cs1/wen=%b, required 001", {db_oe, cs1_o, we_n_o});
    end
    for (int i = 0; i < 80; i++) begin
      if (res_n_o === 1'b0) low_cnt++;
      if (rsp_valid !== 1'b0) rv_cnt++;
      @(negedge clk);
    end
    n_chk++;
    if (rv_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_rsp: got %0d rsp_valid clks, required 0", rv_cnt);
    end
    n_chk++;
    if (low_cnt != 64) begin
      n_fail++;
      $display("FAIL abort_reset_len: res_n_o low for %0d clks, required 64", low_cnt);
    end
    n_chk++;
    if (exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL abort_scoreboard: %0d outstanding, required 1", exp_q.size());
    end
    exp_q.delete();
    $display("ABORT write at phase 5, res_n_o low for %0d clks", low_cnt);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_pend_ignore();
    test_rst_midcycle();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_scoreboard: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mcs6530_bus_master.md
Name: mcs6530_bus_master

Overview:
- 6502-side bus initiator that drives the chip-side pins of the 6530 responder: PHI2, RES, A[9:0], RS0, CS1, R_W, DB[7:0].
- Used as the on-board bus exerciser and host bridge for bring-up and regression of the 6530 core.
- Converts a single-entry host command interface (read/write one byte) into correctly phased 6502 bus cycles.
- Returns read data or write-completion on a response strobe.

Parameters:
- PHI_DIV, 4, clk cycles per PHI2 half-period; minimum 2. One bus cycle = 2*PHI_DIV clk.
- RES_CYCLES, 8, number of full PHI2 cycles res_n_o is held low after rst.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  host command valid.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_addr  input  10  bus address.
- cmd_rs0  input  1  RS0 value for the cycle.
- cmd_wdata  input  8  write data.
- rsp_valid  output  1  one-clk pulse at cycle completion.
- rsp_rdata  output  8  sampled read data; 0x00 for writes.
- phi2_o  output  1  PHI2 clock to the 6530.
- res_n_o  output  1  active-low reset to the 6530.
- a_o  output  10  address.
- rs0_o  output  1  RS0.
- cs1_o  output  1  chip select, active high.
- we_n_o  output  1  R_W: 1 = read, 0 = write.
- db_o  output  8  data out.
- db_oe  output  1  data bus output enable.
- db_i  input  8  data bus in.

Behaviour:
- phase_cnt runs 0..2*PHI_DIV-1 and wraps; free-running, including during RESET_HOLD.
  - phi2_o = 1 when phase_cnt >= PHI_DIV (registered).
  - Cycle boundary is the wrap to 0 (PHI2 fall / phi1 start).
  - "last" means phase_cnt == 2*PHI_DIV-1.
- States:
  - RESET_HOLD:
    - Entered on rst. res_n_o = 0, cmd_ready = 0.
    - Counts RES_CYCLES wraps.
    - res_n_o rises at the phase_cnt 0 after the final count; then go to IDLE.
  - IDLE:
    - Buffer empty; cmd_ready = 1.
    - On accept, latch the command and go to PEND.
  - PEND:
    - cmd_ready = 0.
    - On last: load bus outputs from the latch, go to ACTIVE. The new values are visible at phase_cnt 0.
  - ACTIVE (the bus cycle):
    - Outputs: a_o, rs0_o = command; cs1_o = 1; we_n_o = ~cmd_we.
    - Write: db_o = wdata. db_oe = 1 from phase_cnt PHI_DIV through phase_cnt 0 of the following cycle (one clk hold past the PHI2 fall), then 0.
    - Read: db_oe = 0 throughout.
    - On last:
      - Read: rsp_rdata <= db_i. Write: rsp_rdata <= 0x00.
      - rsp_valid = 1 on the following clk (phase_cnt 0) for exactly one clk.
      - cmd_ready = 1 on last.
      - If a command is accepted on last: stay ACTIVE with the new command, so the bus runs back-to-back with no idle cycle.
      - Otherwise: return to IDLE. At phase_cnt 0 apply idle bus values.
- Idle bus values:
  - cs1_o = 0, we_n_o = 1, db_oe = 0.
  - a_o and rs0_o hold their last value.
- Reset values (on the clk after rst):
  - phase_cnt = 0, phi2_o = 0, res_n_o = 0.
  - cmd_ready = 0, rsp_valid = 0, rsp_rdata = 0x00.
  - a_o = 0, rs0_o = 0, cs1_o = 0, we_n_o = 1, db_o = 0x00, db_oe = 0.
- rst mid-cycle: the cycle is aborted, the pending command is discarded, and no rsp_valid is issued. db_oe drops on the next clk.
- cmd_valid while cmd_ready = 0: ignored. The host must hold cmd_valid and its fields.
- Command fields are sampled only on accept; later changes have no effect.

Test Plan:
- PHI_DIV=4, RES_CYCLES=8: rst for 1 clk -> res_n_o = 0 for 64 clks; phi2_o toggles every 4 clks (50% duty); cmd_ready = 0 until res_n_o = 1, then cmd_ready = 1.
- Write addr 0x3C5, rs0 1, data 0xA5 -> next cycle:
  - a_o = 0x3C5, rs0_o = 1, cs1_o = 1, we_n_o = 0.
  - db_o = 0xA5 with db_oe = 1 for phase_cnt 4..7 and phase_cnt 0 of the next cycle.
  - rsp_valid one clk with rsp_rdata = 0x00.
  - Then cs1_o = 0, we_n_o = 1.
- Read addr 0x200; the bench model drives db_i = 0x5A while phi2_o = 1 -> db_oe stays 0; rsp_rdata = 0x5A; rsp_valid high exactly 1 clk.
- Two reads with cmd_valid held continuously -> second accepted on last of the first cycle; cs1_o stays 1 across both cycles; two rsp_valid pulses exactly 8 clks apart.
- rst asserted at phase_cnt 5 of a write -> db_oe = 0 and cs1_o = 0 next clk; no rsp_valid; res_n_o = 0 for 64 clks.
- cmd_valid asserted during PEND with different fields -> ignored; the bus cycle carries the originally accepted address and data.
